alu_seq_exec: RTL and testbench
===============================

# alu_seq_exec

Sequential execute unit that consumes the 3-bit ALU control code from the ALU decoder, together with two 32-bit operands, and produces a registered result and zero flag. It sits directly downstream of the ALU decoder. It replaces the purely combinational ALU wherever a multi-cycle shifter is acceptable. Add, sub, xor, or and and complete in one cycle; shifts iterate one bit position per cycle unless the barrel option is compiled in.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `SHAMT_W`, default 5: shift-amount width, taken from `b[SHAMT_W-1:0]`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request.
- `ALUcontrol` input 3: operation code from the ALU decoder.
- `a` input XLEN: operand A, typically rs1.
- `b` input XLEN: operand B, rs2 or immediate.
- `flush` input 1: synchronous abort of any in-flight operation.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: registered result.
- `zero` output 1: registered, equals 1 when `result == 0`.

## Operation
ALUcontrol encodings:
- 000: add.
- 010: sub.
- 001: sll.
- 101: srl (logical).
- 100: xor.
- 110: or.
- 111: and.
- 011 is reserved and executes as add.

State machine:
- IDLE: `in_ready` = 1. On `in_valid & in_ready` the unit captures `a`, `b`, the opcode and shamt = `b[4:0]`.
  - Non-shift op: compute, register `result`/`zero`, go to DONE.
  - Shift with shamt = 0: `result` = `a`, go to DONE.
  - Shift with shamt = k > 0: load the working register with `a` and the counter with k, go to SHIFT.
- SHIFT: each cycle, shift the working register by 1 (left for 001, right zero-fill for 101) and decrement the counter. When the counter reaches 0, drive `result`/`zero` from the working register and go to DONE.
- DONE: `out_valid` = 1. `result` and `zero` are held stable. On `out_ready`, go to IDLE. `in_ready` = 0 in DONE, so no accept occurs in the same cycle as the output handshake.

Arithmetic rules:
- Add/sub wrap modulo 2^XLEN; there is no overflow or carry output.
- Only the low 5 bits of `b` are used for shifts; upper bits are ignored.

Flush:
- `flush` = 1 in any state forces IDLE at the next edge.
- The in-flight result is discarded and `out_valid` drops.
- Flush takes priority over `in_valid` (no accept that cycle) and over `out_ready`.

Reset (asynchronous assert, synchronous deassert assumed upstream):
- State = IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 0, counter = 0.
- Reset mid-shift abandons the operation without any output.

## Timing
- Accept at edge N for a non-shift op, or a shift with shamt 0: `out_valid` = 1 after edge N+1.
- Accept at edge N for a shift with shamt k ≥ 1: `out_valid` = 1 after edge N+k.
- Latency is therefore max(1, k) cycles from accept to `out_valid`, and at most 31 cycles.
- Minimum issue interval is 2 cycles: accept, then DONE with `out_ready` = 1, then IDLE.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined: shifts complete in one cycle like all other ops, and the SHIFT state and counter are not generated. Latency is always 1.
- `ALU_BARREL_SHIFT_EN` undefined: iterative one-bit-per-cycle shifter as described above.
- Interface and handshake are identical in both builds.

## Structure
- The shared package `alu_pkg` holds:
  - the ALUcontrol localparams: `ALU_ADD`, `ALU_SUB`, `ALU_SLL`, `ALU_SRL`, `ALU_XOR`, `ALU_OR`, `ALU_AND`;
  - the state encoding typedef (IDLE, SHIFT, DONE).
- The ALU decoder imports the same opcode constants.
- One sub-module, `alu_core`, is combinational and computes the single-cycle ops (and the barrel shift when enabled). `alu_seq_exec` owns the FSM, counter and registers.

## Test plan
- Reset with `rst_n` = 0 mid-SHIFT (shamt 20, 5 cycles in) → `out_valid` = 0, `in_ready` = 1, `result` = 0 immediately; no later output.
- Add/sub: accept a=0x0000_0005, b=0x0000_0007, op 010 → one cycle later `out_valid` = 1, `result` = 0xFFFF_FFFE, `zero` = 0. Then op 000 with a=0xFFFF_FFFF, b=1 → `result` = 0, `zero` = 1.
- Iterative shift: op 001, a=0x0000_0001, b=0x0000_001F → `out_valid` exactly 31 cycles after accept, `result` = 0x8000_0000. Op 101, a=0x8000_0000, b=0x24 (shamt 4) → 4 cycles, `result` = 0x0800_0000.
- Backpressure: hold `out_ready` = 0 for 10 cycles after an xor (a=0xF0F0_F0F0, b=0xFF00_FF00) → `result` = 0x0FF0_0FF0 held stable, `in_ready` = 0 throughout, then IDLE one edge after `out_ready` = 1.
- Flush: flush during SHIFT and in DONE, and flush together with `in_valid` in IDLE → IDLE next edge, `out_valid` = 0, no capture. Reserved op 011, a=2, b=3 → `result` = 5.
- With `ALU_BARREL_SHIFT_EN` defined: repeat the shamt-31 shift → latency 1, same result.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes and execute-unit state encoding
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: single-cycle ALU ops; barrel shifts only when ALU_BARREL_SHIFT_EN is defined
module alu_core import alu_pkg::*; #(
  parameter int XLEN = 32
`ifdef ALU_BARREL_SHIFT_EN
  , parameter int SHAMT_W = 5
`endif
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);
  always_comb begin
    y_o = op_i == ALU_SUB ? a_i - b_i :
          op_i == ALU_XOR ? a_i ^ b_i :
          op_i == ALU_OR  ? a_i | b_i :
          op_i == ALU_AND ? a_i & b_i :
`ifdef ALU_BARREL_SHIFT_EN
          op_i == ALU_SLL ? a_i << b_i[SHAMT_W-1:0] :
          op_i == ALU_SRL ? a_i >> b_i[SHAMT_W-1:0] :
`else
          (op_i == ALU_SLL || op_i == ALU_SRL) ? a_i :
`endif
          a_i + b_i;
  end
endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked execute unit; iterative shifter unless ALU_BARREL_SHIFT_EN is defined
module alu_seq_exec import alu_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ALUcontrol,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  state_e state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, core_y;
  logic zero_q, zero_d;
  alu_core #(
    .XLEN(XLEN)
`ifdef ALU_BARREL_SHIFT_EN
    , .SHAMT_W(SHAMT_W)
`endif
  ) u_core (.op_i(ALUcontrol), .a_i(a), .b_i(b), .y_o(core_y));
`ifndef ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0] work_q, work_d, src, shifted;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, rem;
  logic left_q, left_d, dir_left, stepping, last;
  // The first bit step happens on the accept edge, so a shift by k is done k edges after accept.
  assign stepping = state_q == S_SHIFT || (state_q == S_IDLE && in_valid &&
                    (ALUcontrol == ALU_SLL || ALUcontrol == ALU_SRL) && b[SHAMT_W-1:0] != '0);
  assign dir_left = state_q == S_SHIFT ? left_q : ALUcontrol == ALU_SLL;
  assign src      = state_q == S_SHIFT ? work_q : a;
  assign rem      = state_q == S_SHIFT ? cnt_q : b[SHAMT_W-1:0];
  assign shifted  = dir_left ? src << 1 : src >> 1;
  assign last     = rem == SHAMT_W'(1);
`endif
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef ALU_BARREL_SHIFT_EN
    work_d = work_q;
    cnt_d  = cnt_q;
    left_d = left_q;
`endif
    if (flush) state_d = S_IDLE;
`ifndef ALU_BARREL_SHIFT_EN
    else if (stepping) begin
      work_d   = shifted;
      cnt_d    = rem - SHAMT_W'(1);
      left_d   = dir_left;
      state_d  = last ? S_DONE : S_SHIFT;
      result_d = last ? shifted : result_q;
      zero_d   = last ? shifted == '0 : zero_q;
    end
`endif
    else if (state_q == S_IDLE && in_valid) begin
      state_d  = S_DONE;
      result_d = core_y;
      zero_d   = core_y == '0;
    end
    else if (state_q == S_DONE && out_ready) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      work_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef ALU_BARREL_SHIFT_EN
      work_q <= work_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
`endif
    end
  end
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign result    = result_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and random checks of alu_seq_exec against an arithmetic reference model
module tb_alu_seq_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic [2:0] ALUcontrol = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid, zero;
  logic [31:0] result;
  int tests = 0;
  int fails = 0;

  alu_seq_exec dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUcontrol(ALUcontrol), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int sh = int'(y % 32);
    case (op)
      3'b010: return x - y;
      3'b001: return x << sh;
      3'b101: return x >> sh;
      3'b100: return x ^ y;
      3'b110: return x | y;
      3'b111: return x & y;
      default: return x + y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] y);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    int sh = int'(y % 32);
    return ((op == 3'b001 || op == 3'b101) && sh > 1) ? sh : 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
    int lat;
    logic [31:0] er;
    er = model(op, x, y);
    @(negedge clk);
    ALUcontrol = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_pre", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, model_lat(op, y));
    chk("result", result, er);
    chk("zero", zero, er == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", result, er);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int seen;
    logic [31:0] ry;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(3'b010, 32'h5, 32'h7, 0);
    run_op(3'b000, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(3'b011, 32'h2, 32'h3, 0);
    run_op(3'b001, 32'h1, 32'h1F, 0);
    run_op(3'b101, 32'h8000_0000, 32'h24, 0);
    run_op(3'b001, 32'h1234_5678, 32'h20, 0);
    run_op(3'b101, 32'hF000_0000, 32'h1, 1);
    run_op(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 10);
    run_op(3'b110, 32'h0, 32'h0, 0);
    run_op(3'b111, 32'hFFFF_0000, 32'h0F0F_FFFF, 0);
    // flush during a long shift
    @(negedge clk);
    ALUcontrol = 3'b001; a = 32'h3; b = 32'hA; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_shift_in_ready", in_ready, 1);
    chk("flush_shift_out_valid", out_valid, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    chk("flush_shift_no_output", seen, 0);
    // flush in DONE, with out_ready also high
    @(negedge clk);
    ALUcontrol = 3'b000; a = 32'h10; b = 32'h20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("flush_done_valid", out_valid, 1);
    @(negedge clk) begin flush = 1'b1; out_ready = 1'b1; end
    @(posedge clk);
    #1 begin flush = 1'b0; out_ready = 1'b0; end
    chk("flush_done_out_valid", out_valid, 0);
    chk("flush_done_in_ready", in_ready, 1);
    // flush with in_valid in IDLE: no capture
    @(negedge clk);
    ALUcontrol = 3'b000; a = 32'h1; b = 32'h1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    chk("flush_idle_in_ready", in_ready, 1);
    chk("flush_idle_out_valid", out_valid, 0);
    @(posedge clk);
    #1 chk("flush_idle_no_capture", out_valid, 0);
    for (int i = 0; i < 20; i++) begin
      ry = $urandom;
      if ($urandom_range(0, 1) == 1) ry = ry & 32'h3F;
      run_op(3'($urandom_range(0, 7)), $urandom, ry, int'($urandom_range(0, 2)));
    end
    // asynchronous reset in the middle of a shift by 20
    @(negedge clk);
    ALUcontrol = 3'b001; a = 32'h1; b = 32'h14; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_zero", zero, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    chk("rst_mid_no_output", seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
